// File: rtl/la_iopocseq.sv
// Power-on sequencer for the POC cell: walks the io ring isolate -> ie -> oe -> release, applies cfg updates under isolation.
// All outputs registered; cfg_ready only in ON. Optional vddio_ok synchronizer under LA_IOPOCSEQ_SYNC_EN (+2 cycles on go).
module la_iopocseq #(
  parameter int CFGW  = 16,
  parameter int RINGW = 8,
  parameter int DLY   = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             vddio_ok,
  input  logic [CFGW-1:0]  cfg_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [CFGW-1:0]  cfg,
  output logic [RINGW-1:0] ring,
  output logic             up
);

  localparam int CNTW = $clog2(DLY + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DLY - 1);

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_STABLE = 3'd1;
  localparam logic [2:0] S_IEN    = 3'd2;
  localparam logic [2:0] S_OEN    = 3'd3;
  localparam logic [2:0] S_ON     = 3'd4;
  localparam logic [2:0] S_UPDATE = 3'd5;

  logic             pg;
  logic             go;
  logic             timeout;
  logic             xfer;

  logic [2:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CFGW-1:0]  cfg_q, cfg_d;
  logic [RINGW-1:0] ring_q, ring_d;
  logic             up_q, up_d;
  logic             rdy_q, rdy_d;

`ifdef LA_IOPOCSEQ_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], vddio_ok};
    end
  end

  assign pg = sync_q[1];
`else
  assign pg = vddio_ok;
`endif

  assign go      = en & pg;
  assign timeout = (cnt_q == CNT_LAST);
  assign xfer    = cfg_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    // Abort wins over timeout and over a coincident cfg transfer.
    if ((state_q != S_OFF) && !go) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (go) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end
        end
        S_STABLE, S_IEN, S_OEN, S_UPDATE: begin
          if (timeout) begin
            cnt_d = '0;
            case (state_q)
              S_STABLE: state_d = S_IEN;
              S_IEN:    state_d = S_OEN;
              default:  state_d = S_ON;
            endcase
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        S_ON: begin
          if (xfer) begin
            state_d = S_UPDATE;
            cnt_d   = '0;
            cfg_d   = cfg_in;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Ring outputs are decoded from the next state so they land on the same edge as the transition.
  always_comb begin
    ring_d = '0;
    up_d   = 1'b0;
    rdy_d  = 1'b0;
    case (state_d)
      S_IEN:            ring_d[2:0] = 3'b011;
      S_OEN, S_UPDATE:  ring_d[2:0] = 3'b111;
      S_ON: begin
        ring_d[2:0] = 3'b110;
        up_d        = 1'b1;
        rdy_d       = 1'b1;
      end
      default:          ring_d[2:0] = 3'b001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      cfg_q   <= '0;
      ring_q  <= RINGW'(1);
      up_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      ring_q  <= ring_d;
      up_q    <= up_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cfg       = cfg_q;
  assign ring      = ring_q;
  assign up        = up_q;
  assign cfg_ready = rdy_q;

endmodule

// File: tb/tb_la_iopocseq.sv
// Scoreboard bench for la_iopocseq: stimulus pushes the expected post-edge outputs, a negedge monitor pops and compares.
module tb_la_iopocseq;

    localparam int DLY = 4;
`ifdef LA_IOPOCSEQ_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    typedef struct {
        logic [7:0]  ring;
        logic        up;
        logic        rdy;
        logic [15:0] cfg;
    } exp_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        en;
    logic        vddio_ok;
    logic [15:0] cfg_in;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg;
    logic [7:0]  ring;
    logic        up;

    exp_t        exp_q[$];
    string       name_q[$];
    exp_t        mon_e;
    string       mon_n;
    logic [15:0] exp_cfg;
    int          checks = 0;
    int          errors = 0;
    int          waited;

    la_iopocseq #(.CFGW(16), .RINGW(8), .DLY(DLY)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .en        (en),
        .vddio_ok  (vddio_ok),
        .cfg_in    (cfg_in),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg       (cfg),
        .ring      (ring),
        .up        (up)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if (ring !== mon_e.ring || up !== mon_e.up || cfg_ready !== mon_e.rdy || cfg !== mon_e.cfg) begin
                errors++;
                $display("FAIL %s: got ring=%02h up=%0b rdy=%0b cfg=%04h, want ring=%02h up=%0b rdy=%0b cfg=%04h",
                         mon_n, ring, up, cfg_ready, cfg, mon_e.ring, mon_e.up, mon_e.rdy, mon_e.cfg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $finish;
    end

    // Advance one edge and queue the outputs expected right after it.
    task automatic tick(input logic [7:0] r, input logic u, input logic rd, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.ring = r;
        e.up   = u;
        e.rdy  = rd;
        e.cfg  = exp_cfg;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Immediate comparison of the current outputs.
    task automatic check_now(input logic [7:0] r, input logic u, input logic rd, input logic [15:0] c, input string nm);
        checks++;
        if (ring !== r || up !== u || cfg_ready !== rd || cfg !== c) begin
            errors++;
            $display("FAIL %s: got ring=%02h up=%0b rdy=%0b cfg=%04h, want ring=%02h up=%0b rdy=%0b cfg=%04h",
                     nm, ring, up, cfg_ready, cfg, r, u, rd, c);
        end
    endtask

    // Edge e=0 is the first edge at which go is sampled high (plus lat for the synchronizer).
    task automatic bringup(input int lat, input int n);
        for (int e = 0; e < n; e++) begin
            if (e < DLY + lat)            tick(8'h01, 1'b0, 1'b0, "bu_stable");
            else if (e < 2 * DLY + lat)   tick(8'h03, 1'b0, 1'b0, "bu_ien");
            else if (e < 3 * DLY + lat)   tick(8'h07, 1'b0, 1'b0, "bu_oen");
            else                          tick(8'h06, 1'b1, 1'b1, "bu_on");
        end
    endtask

    initial begin
        nreset    = 1'b0;
        en        = 1'b1;
        vddio_ok  = 1'b1;
        cfg_in    = 16'h0000;
        cfg_valid = 1'b0;
        exp_cfg   = 16'h0000;

        // Reset with go already high, then release.
        tick(8'h01, 1'b0, 1'b0, "reset");
        tick(8'h01, 1'b0, 1'b0, "reset");
        check_now(8'h01, 1'b0, 1'b0, 16'h0000, "reset_state");
        nreset = 1'b1;
        bringup(SL, 3 * DLY + SL + 1);

        // Config update in ON; valid held through UPDATE with a different word.
        cfg_in    = 16'hA5C3;
        cfg_valid = 1'b1;
        exp_cfg   = 16'hA5C3;
        tick(8'h07, 1'b0, 1'b0, "upd_enter");
        cfg_in = 16'h1234;
        for (int i = 1; i < DLY; i++) tick(8'h07, 1'b0, 1'b0, "upd_hold");
        tick(8'h06, 1'b1, 1'b1, "upd_done");
        cfg_valid = 1'b0;
        tick(8'h06, 1'b1, 1'b1, "on_stable");

        // Transfer coinciding with en drop: abort wins, cfg untouched.
        cfg_in    = 16'hBEEF;
        cfg_valid = 1'b1;
        en        = 1'b0;
        tick(8'h01, 1'b0, 1'b0, "abort_xfer");
        cfg_valid = 1'b0;
        tick(8'h01, 1'b0, 1'b0, "off_hold");

        // Drop during STABLE restarts the full count.
        en = 1'b1;
        tick(8'h01, 1'b0, 1'b0, "stable_a");
        tick(8'h01, 1'b0, 1'b0, "stable_b");
        en = 1'b0;
        tick(8'h01, 1'b0, 1'b0, "stable_drop");
        en = 1'b1;
        bringup(0, 3 * DLY + 1);

        // One-cycle vddio_ok glitch during OEN.
        en = 1'b0;
        tick(8'h01, 1'b0, 1'b0, "off2");
        en = 1'b1;
        bringup(0, 2 * DLY + 1);
        vddio_ok = 1'b0;
        tick((SL == 0) ? 8'h01 : 8'h07, 1'b0, 1'b0, "vdd_drop");
        vddio_ok = 1'b1;
        for (int i = 0; i < SL; i++) tick((i == SL - 1) ? 8'h01 : 8'h07, 1'b0, 1'b0, "vdd_drop_sync");
        bringup(0, 3 * DLY + 1);

        // Reset in the middle of UPDATE.
        cfg_in    = 16'h5A5A;
        cfg_valid = 1'b1;
        exp_cfg   = 16'h5A5A;
        tick(8'h07, 1'b0, 1'b0, "upd2_enter");
        cfg_valid = 1'b0;
        tick(8'h07, 1'b0, 1'b0, "upd2_hold");
        nreset  = 1'b0;
        exp_cfg = 16'h0000;
        tick(8'h01, 1'b0, 1'b0, "rst_mid_upd");
        check_now(8'h01, 1'b0, 1'b0, 16'h0000, "rst_mid_upd_state");
        nreset = 1'b1;
        bringup(SL, 3 * DLY + SL + 1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never checked", exp_q.size());
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
